// File: rtl/conv_layer_mc.sv
// conv_layer_mc
//   Multi-channel fixed-point convolution layer. For each pixel it forms
//   OUT_CH dot products of length IN_CH (one input channel per cycle, all
//   output channels in lockstep), adds the per-channel bias, rounds toward
//   minus infinity, saturates to WIDTH bits and optionally applies ReLU.
//   A frame consists of NUM_PIX pixels.
//
// Ports
//   clk            rising-edge clock
//   n_reset        synchronous, active-low reset
//   start          begin a frame (honoured only while idle)
//   relu_en        ReLU mode, captured together with start
//   in_valid       input_feature carries a pixel
//   in_ready       block can take a pixel this cycle
//   input_feature  IN_CH signed WIDTH-bit channels, channel i at [i*WIDTH +: WIDTH]
//   weight         OUT_CH*IN_CH signed weights, weight[o*IN_CH+i]; stable per frame
//   bias           OUT_CH signed biases; stable per frame
//   ready_pool     pooling stage takes output_feature this cycle
//   output_feature OUT_CH signed WIDTH-bit results
//   ready          output_feature is valid
//   busy           a frame is in progress
//   frame_done     one-cycle pulse after the last pixel of a frame is taken
//
// Handshakes: a transfer happens on a rising edge where both sides of a pair
// are high (in_valid & in_ready on the input side, ready & ready_pool on the
// output side). Once ready is high, output_feature and ready stay unchanged
// until that transfer; in_ready never depends on in_valid.

module conv_layer_mc #(
   parameter int IN_CH   = 3,
   parameter int OUT_CH  = 3,
   parameter int WIDTH   = 16,
   parameter int FRAC    = 8,
   parameter int NUM_PIX = 25
) (
   input  logic                            clk,
   input  logic                            n_reset,
   input  logic                            start,
   input  logic                            relu_en,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [IN_CH*WIDTH-1:0]          input_feature,
   input  logic [OUT_CH*IN_CH*WIDTH-1:0]   weight,
   input  logic [OUT_CH*WIDTH-1:0]         bias,
   input  logic                            ready_pool,
   output logic [OUT_CH*WIDTH-1:0]         output_feature,
   output logic                            ready,
   output logic                            busy,
   output logic                            frame_done
);

   // Product, accumulator and post-bias sum widths. The accumulator has
   // enough headroom for IN_CH full-scale products, so it never wraps.
   localparam int PW = 2 * WIDTH;
   localparam int AW = 2 * WIDTH + $clog2(IN_CH) + 1;
   localparam int SW = AW + 1;
   localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
   localparam int NW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

   localparam logic [CW-1:0] LAST_CH  = CW'(IN_CH - 1);
   localparam logic [NW-1:0] LAST_PIX = NW'(NUM_PIX - 1);

   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_MAC  = 3'd2;
   localparam logic [2:0] S_OUT  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]              state;
   logic [NW-1:0]           pix_cnt;
   logic [CW-1:0]           ch;
   logic                    relu_lat;

   logic signed [WIDTH-1:0] in_reg   [IN_CH];
   logic signed [WIDTH-1:0] wt       [OUT_CH][IN_CH];
   logic signed [WIDTH-1:0] b_val    [OUT_CH];
   logic signed [AW-1:0]    acc      [OUT_CH];
   logic signed [AW-1:0]    acc_next [OUT_CH];
   logic signed [PW-1:0]    prod     [OUT_CH];
   logic signed [SW-1:0]    sum      [OUT_CH];
   logic signed [SW-1:0]    shifted  [OUT_CH];
   logic        [WIDTH-1:0] res      [OUT_CH];

   // Unpack the flat weight and bias buses into indexable arrays.
   genvar go, gi;
   generate
      for (go = 0; go < OUT_CH; go++) begin : g_unpack
         assign b_val[go] = bias[go*WIDTH +: WIDTH];
         for (gi = 0; gi < IN_CH; gi++) begin : g_w
            assign wt[go][gi] = weight[(go*IN_CH+gi)*WIDTH +: WIDTH];
         end
      end
   endgenerate

   // Datapath for the current MAC step. acc_next includes the product of
   // this cycle, so on the last step the result is formed directly from it
   // and the output register is loaded on the same edge.
   always_comb begin
      for (int o = 0; o < OUT_CH; o++) begin
         prod[o] = {{WIDTH{in_reg[ch][WIDTH-1]}}, in_reg[ch]}
                 * {{WIDTH{wt[o][ch][WIDTH-1]}}, wt[o][ch]};
         acc_next[o] = acc[o] + {{(AW-PW){prod[o][PW-1]}}, prod[o]};
         // Bias is brought to the product's scale (FRAC extra fraction bits).
         sum[o] = {acc_next[o][AW-1], acc_next[o]}
                + ({{(SW-WIDTH){b_val[o][WIDTH-1]}}, b_val[o]} << FRAC);
         // Arithmetic shift drops fraction bits: truncation toward -inf.
         shifted[o] = sum[o] >>> FRAC;
         if (shifted[o] > SAT_MAX) begin
            res[o] = SAT_MAX[WIDTH-1:0];
         end else if (shifted[o] < SAT_MIN) begin
            res[o] = SAT_MIN[WIDTH-1:0];
         end else begin
            res[o] = shifted[o][WIDTH-1:0];
         end
         if (relu_lat && res[o][WIDTH-1]) begin
            res[o] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state          <= S_IDLE;
         pix_cnt        <= '0;
         ch             <= '0;
         relu_lat       <= 1'b0;
         output_feature <= '0;
         for (int o = 0; o < OUT_CH; o++) begin
            acc[o] <= '0;
         end
         for (int i = 0; i < IN_CH; i++) begin
            in_reg[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  relu_lat <= relu_en;
                  pix_cnt  <= '0;
                  for (int o = 0; o < OUT_CH; o++) begin
                     acc[o] <= '0;
                  end
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  for (int i = 0; i < IN_CH; i++) begin
                     in_reg[i] <= input_feature[i*WIDTH +: WIDTH];
                  end
                  for (int o = 0; o < OUT_CH; o++) begin
                     acc[o] <= '0;
                  end
                  ch    <= '0;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               for (int o = 0; o < OUT_CH; o++) begin
                  acc[o] <= acc_next[o];
               end
               if (ch == LAST_CH) begin
                  for (int o = 0; o < OUT_CH; o++) begin
                     output_feature[o*WIDTH +: WIDTH] <= res[o];
                  end
                  state <= S_OUT;
               end else begin
                  ch <= ch + 1'b1;
               end
            end
            S_OUT: begin
               if (ready_pool) begin
                  if (pix_cnt == LAST_PIX) begin
                     state <= S_DONE;
                  end else begin
                     pix_cnt <= pix_cnt + 1'b1;
                     state   <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = (state == S_LOAD);
   assign ready      = (state == S_OUT);
   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_conv_layer_mc.sv
// tb_conv_layer_mc
//   Self-checking bench for conv_layer_mc. Instance "dut_a" uses the default
//   geometry (3 in, 3 out, 25 pixels); instance "dut_b" uses 1 input channel,
//   4 output channels and single-pixel frames. Expected results come from a
//   plain-arithmetic reference model (64-bit integer dot product, floor
//   scaling, clamping, ReLU).

module tb_conv_layer_mc;

   localparam int W    = 16;
   localparam int A_IC = 3;
   localparam int A_OC = 3;
   localparam int A_NP = 25;
   localparam int B_IC = 1;
   localparam int B_OC = 4;
   localparam int B_NP = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk = ~clk;

   // ---------------- dut_a signals ----------------
   logic                    a_start, a_relu_en, a_in_valid, a_in_ready;
   logic [A_IC*W-1:0]       a_in_feat;
   logic [A_OC*A_IC*W-1:0]  a_weight;
   logic [A_OC*W-1:0]       a_bias, a_out_feat;
   logic                    a_ready_pool, a_ready, a_busy, a_frame_done;

   // ---------------- dut_b signals ----------------
   logic                    b_start, b_relu_en, b_in_valid, b_in_ready;
   logic [B_IC*W-1:0]       b_in_feat;
   logic [B_OC*B_IC*W-1:0]  b_weight;
   logic [B_OC*W-1:0]       b_bias, b_out_feat;
   logic                    b_ready_pool, b_ready, b_busy, b_frame_done;

   conv_layer_mc #(.IN_CH(A_IC), .OUT_CH(A_OC), .WIDTH(W), .FRAC(8), .NUM_PIX(A_NP)) dut_a (
      .clk(clk), .n_reset(n_reset), .start(a_start), .relu_en(a_relu_en),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .input_feature(a_in_feat),
      .weight(a_weight), .bias(a_bias), .ready_pool(a_ready_pool),
      .output_feature(a_out_feat), .ready(a_ready), .busy(a_busy),
      .frame_done(a_frame_done)
   );

   conv_layer_mc #(.IN_CH(B_IC), .OUT_CH(B_OC), .WIDTH(W), .FRAC(8), .NUM_PIX(B_NP)) dut_b (
      .clk(clk), .n_reset(n_reset), .start(b_start), .relu_en(b_relu_en),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .input_feature(b_in_feat),
      .weight(b_weight), .bias(b_bias), .ready_pool(b_ready_pool),
      .output_feature(b_out_feat), .ready(b_ready), .busy(b_busy),
      .frame_done(b_frame_done)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [A_OC*W-1:0] exp_q[$];
   logic signed [W-1:0] cur_x [8];
   logic signed [W-1:0] cur_w [32];
   logic signed [W-1:0] cur_b [8];
   logic [W-1:0] fixed_b [4];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // One output channel: exact dot product, bias scaled by 2^8, floor
   // division by 2^8, clamp to the signed 16-bit range, optional ReLU.
   function automatic logic [W-1:0] ref_ch(input int ic, input int o, input logic relu);
      longint s;
      s = 0;
      for (int i = 0; i < ic; i++) begin
         s += longint'(cur_x[i]) * longint'(cur_w[o*ic+i]);
      end
      s += longint'(cur_b[o]) * 256;
      s = s >>> 8;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      return s[W-1:0];
   endfunction

   function automatic logic [A_OC*W-1:0] ref_vec_a(input logic relu);
      logic [A_OC*W-1:0] v;
      for (int o = 0; o < A_OC; o++) v[o*W +: W] = ref_ch(A_IC, o, relu);
      return v;
   endfunction

   function automatic logic [W-1:0] rnd_s(input int mag);
      int t;
      t = int'($urandom_range(0, 2*mag-1)) - mag;
      return t[W-1:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic pack_a;
      for (int i = 0; i < A_IC; i++) a_in_feat[i*W +: W] = cur_x[i];
      for (int j = 0; j < A_OC*A_IC; j++) a_weight[j*W +: W] = cur_w[j];
      for (int o = 0; o < A_OC; o++) a_bias[o*W +: W] = cur_b[o];
   endtask

   task automatic pack_b;
      for (int i = 0; i < B_IC; i++) b_in_feat[i*W +: W] = cur_x[i];
      for (int j = 0; j < B_OC*B_IC; j++) b_weight[j*W +: W] = cur_w[j];
      for (int o = 0; o < B_OC; o++) b_bias[o*W +: W] = cur_b[o];
   endtask

   task automatic set_uniform(input logic [W-1:0] xv, input logic [W-1:0] wv, input logic [W-1:0] bv);
      for (int i = 0; i < 8; i++) cur_x[i] = xv;
      for (int j = 0; j < 32; j++) cur_w[j] = wv;
      for (int o = 0; o < 8; o++) cur_b[o] = bv;
   endtask

   task automatic rand_data(input int xm, input int wm, input int bm);
      for (int i = 0; i < 8; i++) cur_x[i] = rnd_s(xm);
      for (int j = 0; j < 32; j++) cur_w[j] = rnd_s(wm);
      for (int o = 0; o < 8; o++) cur_b[o] = rnd_s(bm);
   endtask

   task automatic do_reset;
      n_reset = 1'b0;
      tick;
      tick;
      n_reset = 1'b1;
   endtask

   task automatic start_a_frame(input logic relu);
      pack_a;
      a_relu_en = relu;
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
      a_relu_en = ~relu;  // must have been captured already
      check_eq("a_in_ready_after_start", a_in_ready, 1);
   endtask

   // One pixel through dut_a: accept, wait for ready, check result, hold
   // ready_pool low for 'hold' cycles, then complete the output handshake.
   task automatic pixel_a(input logic relu, input int hold, input logic use_fixed, input logic [W-1:0] fixed);
      logic [A_OC*W-1:0] exp, got;
      int lat;
      exp = ref_vec_a(relu);
      if (use_fixed) for (int o = 0; o < A_OC; o++) exp[o*W +: W] = fixed;
      check_eq("a_in_ready_load", a_in_ready, 1);
      pack_a;
      a_in_valid = 1'b1;
      tick;
      a_in_valid = 1'b0;
      lat = 1;
      while (!a_ready && lat < 40) begin
         tick;
         lat++;
      end
      check_eq("a_latency", lat, A_IC + 1);
      got = a_out_feat;
      for (int o = 0; o < A_OC; o++) check_eq($sformatf("a_out_ch%0d", o), got[o*W +: W], exp[o*W +: W]);
      for (int h = 0; h < hold; h++) begin
         tick;
         check_eq("a_hold_ready", a_ready, 1);
         check_eq("a_hold_in_ready", a_in_ready, 0);
         check_eq("a_hold_stable", a_out_feat, got);
      end
      a_ready_pool = 1'b1;
      tick;
      a_ready_pool = 1'b0;
   endtask

   // A whole frame on dut_a with a monitor-driven scoreboard.
   task automatic stream_frame_a(input logic relu, input logic tied, input int xm, input int wm, input int bm);
      logic [A_OC*W-1:0] got, exp;
      int hs, its, early;
      rand_data(xm, wm, bm);
      start_a_frame(relu);
      hs = 0;
      its = 0;
      early = 0;
      while (hs < A_NP && its < 4000) begin
         for (int i = 0; i < A_IC; i++) cur_x[i] = rnd_s(xm);
         pack_a;
         a_in_valid   = tied ? 1'b1 : ($urandom_range(0, 3) != 0);
         a_ready_pool = tied ? 1'b1 : ($urandom_range(0, 2) != 0);
         a_start      = (hs >= 3 && hs < 6);  // must be ignored while busy
         if (a_in_ready && a_in_valid) exp_q.push_back(ref_vec_a(relu));
         if (a_ready && a_ready_pool) begin
            got = a_out_feat;
            check_eq("a_exp_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               for (int o = 0; o < A_OC; o++) check_eq($sformatf("a_frame_ch%0d_px%0d", o, hs), got[o*W +: W], exp[o*W +: W]);
            end
            hs++;
         end
         tick;
         its++;
         if (a_frame_done && hs < A_NP) early++;
      end
      a_start = 1'b0;
      a_in_valid = 1'b0;
      a_ready_pool = 1'b0;
      check_eq("a_handshakes", hs, A_NP);
      if (tied) check_eq("a_frame_cycles", its, A_NP * (A_IC + 2));
      check_eq("a_early_done", early, 0);
      check_eq("a_frame_done_pulse", a_frame_done, 1);
      check_eq("a_ready_after_last", a_ready, 0);
      check_eq("a_busy_in_done", a_busy, 1);
      a_start = 1'b1;  // start during DONE is ignored
      tick;
      a_start = 1'b0;
      check_eq("a_frame_done_one_cycle", a_frame_done, 0);
      check_eq("a_busy_after_done", a_busy, 0);
      tick;
      check_eq("a_idle_after_done_start", a_busy, 0);
      check_eq("a_queue_drained", exp_q.size(), 0);
   endtask

   // A single-pixel frame on dut_b.
   task automatic frame_b(input logic relu, input logic use_fixed);
      logic [W-1:0] exp;
      int lat;
      pack_b;
      b_relu_en = relu;
      b_start = 1'b1;
      tick;
      b_start = 1'b0;
      check_eq("b_in_ready_after_start", b_in_ready, 1);
      b_in_valid = 1'b1;
      tick;
      b_in_valid = 1'b0;
      lat = 1;
      while (!b_ready && lat < 40) begin
         tick;
         lat++;
      end
      check_eq("b_latency", lat, B_IC + 1);
      for (int o = 0; o < B_OC; o++) begin
         exp = use_fixed ? fixed_b[o] : ref_ch(B_IC, o, relu);
         check_eq($sformatf("b_out_ch%0d", o), b_out_feat[o*W +: W], exp);
      end
      b_ready_pool = 1'b1;
      tick;
      b_ready_pool = 1'b0;
      check_eq("b_frame_done", b_frame_done, 1);
      check_eq("b_ready_after_last", b_ready, 0);
      tick;
      check_eq("b_busy_after_done", b_busy, 0);
      check_eq("b_frame_done_one_cycle", b_frame_done, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      a_start = 0; a_relu_en = 0; a_in_valid = 0; a_ready_pool = 0;
      a_in_feat = '0; a_weight = '0; a_bias = '0;
      b_start = 0; b_relu_en = 0; b_in_valid = 0; b_ready_pool = 0;
      b_in_feat = '0; b_weight = '0; b_bias = '0;
      fixed_b[0] = 16'h0200; fixed_b[1] = 16'h0100; fixed_b[2] = 16'hFF00; fixed_b[3] = 16'h0000;

      // reset state
      n_reset = 1'b0;
      tick;
      tick;
      check_eq("rst_a_in_ready", a_in_ready, 0);
      check_eq("rst_a_ready", a_ready, 0);
      check_eq("rst_a_busy", a_busy, 0);
      check_eq("rst_a_frame_done", a_frame_done, 0);
      check_eq("rst_a_out", a_out_feat, 0);
      check_eq("rst_b_out", b_out_feat, 0);
      check_eq("rst_b_busy", b_busy, 0);
      n_reset = 1'b1;
      tick;
      check_eq("idle_no_start_in_ready", a_in_ready, 0);

      // basic dot product with 5 cycles of backpressure
      set_uniform(16'h0100, 16'h0100, 16'h0080);
      start_a_frame(1'b0);
      pixel_a(1'b0, 5, 1'b1, 16'h0380);
      check_eq("a_back_to_load", a_in_ready, 1);
      check_eq("a_busy_mid_frame", a_busy, 1);

      // reset in the middle of MAC, then a clean pixel
      rand_data(2048, 512, 4096);
      pack_a;
      a_in_valid = 1'b1;
      tick;
      a_in_valid = 1'b0;
      tick;
      n_reset = 1'b0;
      tick;
      n_reset = 1'b1;
      check_eq("mac_rst_in_ready", a_in_ready, 0);
      check_eq("mac_rst_ready", a_ready, 0);
      check_eq("mac_rst_busy", a_busy, 0);
      check_eq("mac_rst_frame_done", a_frame_done, 0);
      check_eq("mac_rst_out", a_out_feat, 0);
      tick;
      check_eq("mac_rst_no_done", a_frame_done, 0);
      rand_data(2048, 512, 4096);
      start_a_frame(1'b0);
      pixel_a(1'b0, 0, 1'b0, '0);

      // saturation and sign
      do_reset;
      set_uniform(16'h7FFF, 16'h7FFF, 16'h0000);
      start_a_frame(1'b0);
      pixel_a(1'b0, 0, 1'b1, 16'h7FFF);
      do_reset;
      set_uniform(16'h7FFF, 16'h8000, 16'h0000);
      start_a_frame(1'b0);
      pixel_a(1'b0, 0, 1'b1, 16'h8000);
      do_reset;
      set_uniform(16'h0100, 16'hFF00, 16'h0000);
      start_a_frame(1'b0);
      pixel_a(1'b0, 0, 1'b1, 16'hFD00);
      do_reset;
      start_a_frame(1'b1);
      pixel_a(1'b1, 0, 1'b1, 16'h0000);

      // full frames
      do_reset;
      stream_frame_a(1'b0, 1'b1, 2048, 512, 4096);
      stream_frame_a(1'b1, 1'b0, 2048, 512, 4096);
      stream_frame_a(1'b0, 1'b0, 32768, 32768, 32768);

      // dut_b: one input channel, four outputs, one pixel per frame
      set_uniform(16'h0200, 16'h0000, 16'h0000);
      cur_w[0] = 16'h0100; cur_w[1] = 16'h0080; cur_w[2] = 16'hFF80; cur_w[3] = 16'h0000;
      frame_b(1'b0, 1'b1);
      for (int n = 0; n < 6; n++) begin
         rand_data(8192, 1024, 8192);
         frame_b(1'($urandom_range(0, 1)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
